updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo counter; next generation of the team's 4-bit T-flip-flop binary counter. Adds configurable width and modulus, direction control, parallel load, synchronous clear, wrap-or-saturate mode and carry/overflow reporting. It serves as the general-purpose sequencing and iteration counter for FPU control paths, such as normalisation shift counts and iteration loops.

---
 rtl/updown_mod_counter.sv | 55 +++++
 tb/tb_updown_mod_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with load, clear, wrap/saturate and carry/overflow
module updown_mod_counter #(
   parameter int     WIDTH = 8,
   parameter longint MOD   = 256,
   parameter bit     SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             carry,
   output logic             ovf
);

   // terminal value fits WIDTH, so every compare and step stays in WIDTH bits
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 64'd1);

   logic at_top;
   logic at_bot;

   assign at_top = (count == MAX);
   assign at_bot = (count == '0);
   assign tc     = en & ((up & at_top) | (~up & at_bot));

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= (din > MAX) ? MAX : din;
         carry <= 1'b0;
      end else if (en) begin
         carry <= tc;
         if (tc)
            ovf <= 1'b1;
         if (up)
            count <= at_top ? (SAT ? MAX : '0) : count + WIDTH'(1);
         else
            count <= at_bot ? (SAT ? '0 : MAX) : count - WIDTH'(1);
      end else begin
         carry <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - randomized and directed bench for updown_mod_counter against an arithmetic model
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load, clr;
   logic [3:0] din4;
   logic [7:0] din8;

   logic [3:0] count_w, count_s;
   logic [7:0] count_b;
   logic       tc_w, tc_s, tc_b;
   logic       carry_w, carry_s, carry_b;
   logic       ovf_w, ovf_s, ovf_b;

   int n_tests = 0;
   int n_fail  = 0;

   // instance 0: 4-bit mod 10 wrap, 1: 4-bit mod 10 saturate, 2: 8-bit mod 256 wrap
   int mods[3] = '{10, 10, 256};
   int sats[3] = '{0, 1, 0};
   int m_count[3];
   int m_carry[3];
   int m_ovf[3];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MOD(10), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din4), .clr(clr),
      .count(count_w), .tc(tc_w), .carry(carry_w), .ovf(ovf_w));

   updown_mod_counter #(.WIDTH(4), .MOD(10), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din4), .clr(clr),
      .count(count_s), .tc(tc_s), .carry(carry_s), .ovf(ovf_s));

   updown_mod_counter #(.WIDTH(8), .MOD(256), .SAT(1'b0)) u_bin (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din8), .clr(clr),
      .count(count_b), .tc(tc_b), .carry(carry_b), .ovf(ovf_b));

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_tc(input int i, input logic e, input logic u);
      return (e && ((u && m_count[i] == mods[i] - 1) || (!u && m_count[i] == 0))) ? 1 : 0;
   endfunction

   task automatic model_step(input int i, input logic r, input logic c, input logic l,
                             input logic e, input logic u, input int d);
      int t;
      if (!r || c) begin
         m_count[i] = 0; m_carry[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
         m_count[i] = (d > mods[i] - 1) ? mods[i] - 1 : d;
         m_carry[i] = 0;
      end else if (e) begin
         t = model_tc(i, e, u);
         m_carry[i] = t;
         if (t == 1) m_ovf[i] = 1;
         if (t == 1 && sats[i] == 1)
            m_count[i] = m_count[i];
         else if (u)
            m_count[i] = (m_count[i] + 1) % mods[i];
         else
            m_count[i] = (m_count[i] + mods[i] - 1) % mods[i];
      end else begin
         m_carry[i] = 0;
      end
   endtask

   task automatic cycle(input logic r, input logic c, input logic l,
                        input logic e, input logic u, input int d);
      rst = r; clr = c; load = l; en = e; up = u;
      din4 = d[3:0]; din8 = d[7:0];
      #1;
      check("tc_wrap", int'(tc_w), model_tc(0, e, u));
      check("tc_sat",  int'(tc_s), model_tc(1, e, u));
      check("tc_bin",  int'(tc_b), model_tc(2, e, u));
      @(posedge clk);
      model_step(0, r, c, l, e, u, d & 15);
      model_step(1, r, c, l, e, u, d & 15);
      model_step(2, r, c, l, e, u, d & 255);
      #1;
      check("count_wrap", int'(count_w), m_count[0]);
      check("carry_wrap", int'(carry_w), m_carry[0]);
      check("ovf_wrap",   int'(ovf_w),   m_ovf[0]);
      check("count_sat",  int'(count_s), m_count[1]);
      check("carry_sat",  int'(carry_s), m_carry[1]);
      check("ovf_sat",    int'(ovf_s),   m_ovf[1]);
      check("count_bin",  int'(count_b), m_count[2]);
      check("carry_bin",  int'(carry_b), m_carry[2]);
      check("ovf_bin",    int'(ovf_b),   m_ovf[2]);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_count[i] = 0; m_carry[i] = 0; m_ovf[i] = 0;
      end
      rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; din4 = '0; din8 = '0;
      @(posedge clk); #1;

      // reset and hold
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("reset_count", int'(count_w), 0);

      // wrap up: 1..9, 0, 1, 2
      repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("wrap_up_count", int'(count_w), 2);
      check("wrap_up_ovf",   int'(ovf_w), 1);
      check("sat_up_count",  int'(count_s), 9);

      // wrap down and saturate from 0
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("down_wrap_count", int'(count_w), 9);
      check("down_wrap_carry", int'(carry_w), 1);
      check("down_sat_count",  int'(count_s), 0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("down_sat_carry", int'(carry_s), 1);
      check("down_sat_ovf",   int'(ovf_s), 1);

      // load priority, clamp, clear over load
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7);
      check("load_no_step", int'(count_w), 7);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 13);
      check("load_clamp", int'(count_w), 9);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5);
      check("clr_over_load", int'(count_w), 0);

      // mid-operation reset with ovf set
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("pre_rst_count", int'(count_w), 5);
      check("pre_rst_ovf",   int'(ovf_w), 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("mid_rst_ovf", int'(ovf_w), 0);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("resume_count", int'(count_w), 2);

      // full binary range on the 8-bit instance
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 254);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("bin_255", int'(count_b), 255);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("bin_wrap_0",  int'(count_b), 0);
      check("bin_carry_0", int'(carry_b), 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check("bin_1",       int'(count_b), 1);
      check("bin_carry_1", int'(carry_b), 0);

      // randomized traffic against the model
      for (int k = 0; k < 1000; k++) begin
         logic r, c, l, e, u;
         r = ($urandom_range(0, 99) >= 2);
         c = ($urandom_range(0, 99) < 4);
         l = ($urandom_range(0, 99) < 10);
         e = ($urandom_range(0, 99) < 75);
         u = $urandom_range(0, 1) == 1;
         cycle(r, c, l, e, u, int'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
